// File: rtl/mux8_rr_scheduler_if.sv
// Handshake bundle between the eight requesters/consumer and mux8_rr_scheduler.
// Carries chan_mask only when MUX_SCHED_MASK_EN is defined.
interface mux8_rr_scheduler_if #(
  parameter int DW = 1
);
  logic [7:0]      req;
  logic [8*DW-1:0] data_in;
  logic            out_ready;
  logic [2:0]      sel;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic [7:0]      ack;
  logic            busy;
`ifdef MUX_SCHED_MASK_EN
  logic [7:0]      chan_mask;

  modport master (
    output req, data_in, out_ready, chan_mask,
    input  sel, out_data, out_valid, ack, busy
  );

  modport slave (
    input  req, data_in, out_ready, chan_mask,
    output sel, out_data, out_valid, ack, busy
  );
`else
  modport master (
    output req, data_in, out_ready,
    input  sel, out_data, out_valid, ack, busy
  );

  modport slave (
    input  req, data_in, out_ready,
    output sel, out_data, out_valid, ack, busy
  );
`endif
endinterface

// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler sharing one 8:1 mux among eight requesters, valid/ready output.
// Optional per-channel eligibility mask enabled by defining MUX_SCHED_MASK_EN.
module mux8_rr_scheduler #(
  parameter int DW = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux8_rr_scheduler_if.slave   bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state;
  logic [2:0]      ptr;
  logic [2:0]      sel_q;
  logic [DW-1:0]   data_q;
  logic            valid_q;
  logic            busy_q;

  logic [7:0]      elig;
  logic [15:0]     elig_dbl;
  logic [7:0]      elig_rot;
  logic [2:0]      winner;
  logic [DW-1:0]   win_data;
  logic [7:0]      ack_c;

  // Index of the lowest set bit; only meaningful when v is non-zero.
  function automatic logic [2:0] first_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

`ifdef MUX_SCHED_MASK_EN
  assign elig = bus.req & ~bus.chan_mask;
`else
  assign elig = bus.req;
`endif

  // Rotate so bit 0 is channel ptr; the winner offset then wraps naturally in 3 bits.
  assign elig_dbl = {elig, elig};
  assign elig_rot = 8'(elig_dbl >> ptr);
  assign winner   = ptr + first_set(elig_rot);

  always_comb begin
    win_data = '0;
    for (int i = 0; i < 8; i++) begin
      if (winner == 3'(i)) win_data = bus.data_in[i*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|elig) begin
            sel_q   <= winner;
            data_q  <= win_data;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state   <= GRANT;
          end
        end
        GRANT: begin
          // Captured data is held regardless of req/data_in until the consumer takes it.
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ptr     <= sel_q + 3'd1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ack_c = '0;
    if (busy_q && bus.out_ready) ack_c[sel_q] = 1'b1;
  end

  assign bus.sel       = sel_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.ack       = ack_c;

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Directed self-checking bench for mux8_rr_scheduler (DW=4).
// Define MUX_SCHED_MASK_EN to also exercise the channel mask.
module tb_mux8_rr_scheduler;

  localparam int DW = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mux8_rr_scheduler_if #(.DW(DW)) bus ();

  mux8_rr_scheduler #(.DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.data_in   = '0;
    bus.out_ready = 1'b0;
`ifdef MUX_SCHED_MASK_EN
    bus.chan_mask = '0;
`endif
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.req       = 8'hFF;
    bus.data_in   = {8{4'hF}};
    bus.out_ready = 1'b1;
`ifdef MUX_SCHED_MASK_EN
    bus.chan_mask = '0;
`endif
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (bus.sel !== 3'd0 || bus.out_valid !== 1'b0 || bus.ack !== 8'h00 ||
          bus.busy !== 1'b0 || bus.out_data !== 4'h0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: sel=%0d valid=%b ack=%h busy=%b data=%h, want 0/0/00/0/0",
                 c, bus.sel, bus.out_valid, bus.ack, bus.busy, bus.out_data);
      end
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.sel !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_release: valid=%b sel=%0d, want 1/0", bus.out_valid, bus.sel);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.req              = 8'h08;
    bus.data_in[12 +: 4] = 4'h1;
    bus.out_ready        = 1'b1;
    step();
    n_checks++;
    if (bus.sel !== 3'd3 || bus.out_data !== 4'h1 || bus.out_valid !== 1'b1 ||
        bus.busy !== 1'b1 || bus.ack !== 8'h08) begin
      n_fail++;
      $display("FAIL single_grant: sel=%0d data=%h valid=%b busy=%b ack=%h, want 3/1/1/1/08",
               bus.sel, bus.out_data, bus.out_valid, bus.busy, bus.ack);
    end
    bus.req = 8'h00;
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.ack !== 8'h00) begin
      n_fail++;
      $display("FAIL single_idle: valid=%b busy=%b ack=%h, want 0/0/00",
               bus.out_valid, bus.busy, bus.ack);
    end
  endtask

  task automatic test_rotation();
    logic [2:0] exp_ch;
    do_reset();
    for (int i = 0; i < 8; i++) bus.data_in[i*DW +: DW] = 4'(i + 1);
    bus.req       = 8'hFF;
    bus.out_ready = 1'b1;
    exp_ch        = 3'd0;
    for (int g = 0; g < 9; g++) begin
      step();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.sel !== exp_ch ||
          bus.out_data !== 4'(exp_ch + 4'd1) || bus.ack !== (8'h01 << exp_ch)) begin
        n_fail++;
        $display("FAIL rotation_grant%0d: valid=%b sel=%0d data=%h ack=%h, want 1/%0d/%h/%h",
                 g, bus.out_valid, bus.sel, bus.out_data, bus.ack,
                 exp_ch, 4'(exp_ch + 4'd1), 8'h01 << exp_ch);
      end
      step();
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.ack !== 8'h00) begin
        n_fail++;
        $display("FAIL rotation_bubble%0d: valid=%b ack=%h, want 0/00", g, bus.out_valid, bus.ack);
      end
      exp_ch = exp_ch + 3'd1;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.req              = 8'h21;
    bus.data_in[0 +: 4]  = 4'hA;
    bus.data_in[20 +: 4] = 4'h5;
    bus.out_ready        = 1'b0;
    step();
    bus.data_in[0 +: 4] = 4'h3;
    bus.req             = 8'h20;
    for (int c = 0; c < 5; c++) begin
      step();
      n_checks++;
      if (bus.sel !== 3'd0 || bus.out_valid !== 1'b1 || bus.out_data !== 4'hA ||
          bus.ack !== 8'h00 || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL backpressure_hold%0d: sel=%0d valid=%b data=%h ack=%h busy=%b, want 0/1/a/00/1",
                 c, bus.sel, bus.out_valid, bus.out_data, bus.ack, bus.busy);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.ack !== 8'h01) begin
      n_fail++;
      $display("FAIL backpressure_ack: ack=%h, want 01", bus.ack);
    end
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.ack !== 8'h00) begin
      n_fail++;
      $display("FAIL backpressure_bubble: valid=%b ack=%h, want 0/00", bus.out_valid, bus.ack);
    end
    step();
    n_checks++;
    if (bus.sel !== 3'd5 || bus.out_valid !== 1'b1 || bus.out_data !== 4'h5 || bus.ack !== 8'h20) begin
      n_fail++;
      $display("FAIL backpressure_next: sel=%0d valid=%b data=%h ack=%h, want 5/1/5/20",
               bus.sel, bus.out_valid, bus.out_data, bus.ack);
    end
    bus.req = 8'h00;
    step();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    bus.req       = 8'h04;
    bus.out_ready = 1'b1;
    step();
    bus.req = 8'h00;
    step();
    bus.req              = 8'h40;
    bus.data_in[24 +: 4] = 4'h6;
    bus.out_ready        = 1'b0;
    step();
    n_checks++;
    if (bus.sel !== 3'd6 || bus.out_valid !== 1'b1 || bus.out_data !== 4'h6) begin
      n_fail++;
      $display("FAIL midrst_grant: sel=%0d valid=%b data=%h, want 6/1/6",
               bus.sel, bus.out_valid, bus.out_data);
    end
    #2;
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.sel !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_data !== 4'h0 ||
        bus.ack !== 8'h00 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_cleared: sel=%0d valid=%b data=%h ack=%h busy=%b, want 0/0/0/00/0",
               bus.sel, bus.out_valid, bus.out_data, bus.ack, bus.busy);
    end
    step();
    rst_n         = 1'b1;
    bus.req       = 8'h41;
    bus.out_ready = 1'b0;
    step();
    n_checks++;
    if (bus.sel !== 3'd0 || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_restart: sel=%0d valid=%b, want 0/1", bus.sel, bus.out_valid);
    end
  endtask

  task automatic test_ready_idle();
    do_reset();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (bus.ack !== 8'h00 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL ready_idle%0d: ack=%h valid=%b busy=%b, want 00/0/0",
                 c, bus.ack, bus.out_valid, bus.busy);
      end
    end
  endtask

`ifdef MUX_SCHED_MASK_EN
  task automatic test_mask();
    logic [2:0] exp_ch;
    do_reset();
    bus.chan_mask = 8'h0F;
    bus.req       = 8'hFF;
    bus.out_ready = 1'b1;
    exp_ch        = 3'd4;
    for (int g = 0; g < 5; g++) begin
      step();
      n_checks++;
      if (bus.sel !== exp_ch || bus.out_valid !== 1'b1 || bus.ack !== (8'h01 << exp_ch)) begin
        n_fail++;
        $display("FAIL mask_grant%0d: sel=%0d valid=%b ack=%h, want %0d/1/%h",
                 g, bus.sel, bus.out_valid, bus.ack, exp_ch, 8'h01 << exp_ch);
      end
      step();
      exp_ch = (exp_ch == 3'd7) ? 3'd4 : exp_ch + 3'd1;
    end
    bus.chan_mask = 8'h00;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_reset_mid_grant();
    test_ready_idle();
`ifdef MUX_SCHED_MASK_EN
    test_mask();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
